// File: rtl/sram_write_driver_ctrl_pkg.sv
// Shared types and defaults for the SRAM column write driver.
package sram_wr_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRECHARGE = 2'd1;
  localparam logic [1:0] ST_DRIVE     = 2'd2;
  localparam logic [1:0] ST_RECOVER   = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    PRECHARGE = ST_PRECHARGE,
    DRIVE     = ST_DRIVE,
    RECOVER   = ST_RECOVER
  } state_e;

  localparam int unsigned DEF_PRE_CYCLES   = 2;
  localparam int unsigned DEF_DRIVE_CYCLES = 3;
  localparam int unsigned DEF_CNT_W        = 4;

  // Smallest counter width that can hold max(pre, drv) - 1.
  function automatic int unsigned calc_cnt_w(input int unsigned pre, input int unsigned drv);
    int unsigned mx;
    mx = (pre > drv) ? pre : drv;
    return (mx <= 2) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/sram_write_driver_ctrl_if.sv
// Write-request handshake between the SRAM controller and the column write driver.
interface sram_write_driver_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [WIDTH-1:0] req_mask;

  modport master (output req_valid, output req_data, output req_mask, input req_ready);
  modport slave  (input req_valid, input req_data, input req_mask, output req_ready);
endinterface

// File: rtl/sram_write_driver_ctrl_timer.sv
// Loadable down-counter timing the precharge and drive phases.
module sram_phase_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_write_driver_ctrl.sv
// SRAM column write driver: accepts a masked word, then sequences precharge -> drive -> recover.
module sram_write_driver_ctrl
  import sram_wr_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PRE_CYCLES   = DEF_PRE_CYCLES,
  parameter int unsigned DRIVE_CYCLES = DEF_DRIVE_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  sram_write_driver_ctrl_if.slave req,
  input  logic                    rd_active,
  output logic                    precharge_b,
  output logic                    wl_en,
  output logic                    wr_en,
  // True bitline drive; 'bit' is a reserved word in SystemVerilog.
  output logic [WIDTH-1:0]        bit_true,
  output logic [WIDTH-1:0]        bit_bar,
  output logic                    done
);

  state_e           state;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic             accept;
  logic             drive;
  logic             t_load;
  logic             t_en;
  logic             t_zero;
  logic [CNT_W-1:0] t_value;

  assign req.req_ready = (state == IDLE) && !rd_active && !reset;
  assign accept        = req.req_valid && req.req_ready;

  // One timer serves both phases: loaded on accept and again on leaving precharge.
  assign t_load  = accept || ((state == PRECHARGE) && t_zero);
  assign t_value = accept ? CNT_W'(PRE_CYCLES - 1) : CNT_W'(DRIVE_CYCLES - 1);
  assign t_en    = (state == PRECHARGE) || (state == DRIVE);

  sram_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .en    (t_en),
    .value (t_value),
    .zero  (t_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:      if (accept) state <= PRECHARGE;
        PRECHARGE: if (t_zero) state <= DRIVE;
        DRIVE:     if (t_zero) state <= RECOVER;
        RECOVER:   state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Write word is held only by the accept strobe; reset leaves it untouched.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= req.req_data;
      mask_q <= req.req_mask;
    end
  end

  always_comb begin
    drive       = (state == DRIVE);
    precharge_b = drive;
    wl_en       = drive;
    wr_en       = drive;
    done        = (state == RECOVER);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_col
    assign bit_true[i] = !(drive && mask_q[i]) || data_q[i];
    assign bit_bar[i]  = !(drive && mask_q[i]) || !data_q[i];
  end

endmodule
